// File: rtl/mode_cmd_arbiter_pkg.sv
// Shared definitions for the mode command arbiter: mode FSM encodings,
// controller state enum and the next_mode transition function.
package mode_cmd_arbiter_pkg;

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } ctl_state_t;

   // Mode reached when cmd is applied in state cur.
   // S3 remaps commands; all other states jump straight to cmd.
   function automatic logic [1:0] next_mode(input logic [1:0] cur,
                                            input logic [1:0] cmd);
      logic [1:0] r;
      r = cmd;
      if (cur == S3) begin
         case (cmd)
            S0:      r = S2;
            S1:      r = S1;
            S2:      r = S0;
            default: r = S3;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/mode_cmd_arbiter_rr_pick2.sv
// Two-way round-robin selector, purely combinational.
// Ports: req (requests), ptr (preferred index), sel (chosen index), any (some req).
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       sel,
   output logic       any
);

   always_comb begin
      any = |req;
      sel = req[ptr] ? ptr : ~ptr;
   end

endmodule

// File: rtl/mode_cmd_arbiter.sv
// Arbitrates two command requesters onto a 4-state mode FSM and waits for it
// to reach the target mode, flagging a timeout.
// Ports: clk, rst (async, active-high), req, cmd0, cmd1, cur_state in;
//        gnt, x_out, x_valid, busy, done, err, owner out.
module mode_cmd_arbiter
   import mode_cmd_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] cmd0,
   input  logic [1:0] cmd1,
   input  logic [1:0] cur_state,
   output logic [1:0] gnt,
   output logic [1:0] x_out,
   output logic       x_valid,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       owner
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   ctl_state_t    state, state_d;
   logic          rr_ptr, rr_ptr_d;
   logic          sel_q, sel_q_d;
   logic [1:0]    target, target_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [1:0]    gnt_d, x_out_d;
   logic          x_valid_d, done_d, err_d, owner_d;
   logic          pick_sel, pick_any;

   rr_pick2 u_pick (
      .req (req),
      .ptr (rr_ptr),
      .sel (pick_sel),
      .any (pick_any)
   );

   assign busy = (state != ST_IDLE);

   always_comb begin
      state_d   = state;
      rr_ptr_d  = rr_ptr;
      sel_q_d   = sel_q;
      target_d  = target;
      cnt_d     = cnt;
      gnt_d     = 2'b00;
      x_out_d   = x_out;
      x_valid_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      owner_d   = owner;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               sel_q_d = pick_sel;
               gnt_d   = pick_sel ? 2'b10 : 2'b01;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // capture is unconditional; req may already be gone
            owner_d   = sel_q;
            x_out_d   = sel_q ? cmd1 : cmd0;
            x_valid_d = 1'b1;
            state_d   = ST_ISSUE;
         end
         ST_ISSUE: begin
            target_d = next_mode(cur_state, x_out);
            cnt_d    = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // a match wins over a timeout landing in the same cycle
            if (cur_state == target) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (cnt == CNT_LAST) begin
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (cnt != '1) begin
               cnt_d = cnt + CW'(1);
            end
         end
         ST_DONE: begin
            rr_ptr_d = ~owner;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= 1'b0;
         sel_q   <= 1'b0;
         target  <= 2'b00;
         cnt     <= '0;
         gnt     <= 2'b00;
         x_out   <= 2'b00;
         x_valid <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         owner   <= 1'b0;
      end else begin
         state   <= state_d;
         rr_ptr  <= rr_ptr_d;
         sel_q   <= sel_q_d;
         target  <= target_d;
         cnt     <= cnt_d;
         gnt     <= gnt_d;
         x_out   <= x_out_d;
         x_valid <= x_valid_d;
         done    <= done_d;
         err     <= err_d;
         owner   <= owner_d;
      end
   end

endmodule

// File: tb/tb_mode_cmd_arbiter.sv
// Scoreboard bench for mode_cmd_arbiter: directed scenarios push expected
// grant / issue / done events; a negedge monitor pops and compares them.
module tb_mode_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req, cmd0, cmd1, cur_state;
   logic [1:0] gnt, x_out;
   logic       x_valid, busy, done, err, owner;

   always #5 clk = ~clk;

   mode_cmd_arbiter #(.TIMEOUT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .cmd0      (cmd0),
      .cmd1      (cmd1),
      .cur_state (cur_state),
      .gnt       (gnt),
      .x_out     (x_out),
      .x_valid   (x_valid),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .owner     (owner)
   );

   typedef struct {
      int         kind;
      logic [1:0] val;
      logic       own;
      int         cyc;
   } ev_t;

   ev_t q[$];
   int  chk = 0;
   int  errs = 0;
   int  cyc = 0;
   int  n_gnt = 0;
   int  n_done = 0;

   logic       follow = 1'b0;
   logic       load = 1'b0;
   logic [1:0] load_val = 2'b00;
   logic [1:0] model;

   assign cur_state = model;

   function automatic logic [1:0] ref_next(input logic [1:0] s,
                                           input logic [1:0] c);
      logic [1:0] tbl [4];
      tbl = '{2'd2, 2'd1, 2'd0, 2'd3};
      return (s == 2'd3) ? tbl[c] : c;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst)
         model <= 2'b00;
      else if (load)
         model <= load_val;
      else if (follow && x_valid)
         model <= ref_next(model, x_out);
   end

   always @(negedge clk) begin
      if (!rst && (gnt != 2'b00 || x_valid || done)) begin
         ev_t o;
         ev_t e;
         o.kind = x_valid ? 1 : (done ? 2 : 0);
         o.val  = x_valid ? x_out : (done ? {1'b0, err} : gnt);
         o.own  = x_valid ? owner : 1'b0;
         o.cyc  = cyc;
         if (o.kind == 0) n_gnt = n_gnt + 1;
         if (o.kind == 2) n_done = n_done + 1;
         chk = chk + 1;
         if (q.size() == 0) begin
            errs = errs + 1;
            $display("FAIL unexpected_event kind=%0d val=%0d own=%0d cyc=%0d",
                     o.kind, o.val, o.own, o.cyc);
         end else begin
            e = q.pop_front();
            if (o.kind != e.kind || o.val !== e.val || o.own !== e.own ||
                (e.cyc >= 0 && o.cyc != e.cyc)) begin
               errs = errs + 1;
               $display("FAIL event got kind=%0d val=%0d own=%0d cyc=%0d want kind=%0d val=%0d own=%0d cyc=%0d",
                        o.kind, o.val, o.own, o.cyc,
                        e.kind, e.val, e.own, e.cyc);
            end
         end
      end
   end

   task automatic expect_ev(input int k, input logic [1:0] v,
                            input logic o, input int cy);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.own  = o;
      e.cyc  = cy;
      q.push_back(e);
   endtask

   task automatic chkv(input string nm, input logic [7:0] act,
                       input logic [7:0] want);
      chk = chk + 1;
      if (act !== want) begin
         errs = errs + 1;
         $display("FAIL %s got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic sync();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int target);
      int t;
      t = 0;
      while (n_gnt < target && t < 300) begin
         sync();
         t++;
      end
      chk = chk + 1;
      if (n_gnt < target) begin
         errs = errs + 1;
         $display("FAIL gnt_timeout got %0d want %0d", n_gnt, target);
      end
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (n_done < target && t < 300) begin
         sync();
         t++;
      end
      chk = chk + 1;
      if (n_done < target) begin
         errs = errs + 1;
         $display("FAIL done_timeout got %0d want %0d", n_done, target);
      end
   endtask

   task automatic set_model(input logic [1:0] v);
      load_val = v;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      sync();
   endtask

   task automatic check_zero(input string tag);
      chkv({tag, "_gnt"}, {6'd0, gnt}, 8'd0);
      chkv({tag, "_x_out"}, {6'd0, x_out}, 8'd0);
      chkv({tag, "_x_valid"}, {7'd0, x_valid}, 8'd0);
      chkv({tag, "_busy"}, {7'd0, busy}, 8'd0);
      chkv({tag, "_done"}, {7'd0, done}, 8'd0);
      chkv({tag, "_err"}, {7'd0, err}, 8'd0);
      chkv({tag, "_owner"}, {7'd0, owner}, 8'd0);
   endtask

   initial begin
      int c;
      rst  = 1'b1;
      req  = 2'b00;
      cmd0 = 2'b00;
      cmd1 = 2'b00;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      sync();

      // single requester, model follows: 4-cycle latency
      follow = 1'b1;
      c = cyc;
      expect_ev(0, 2'b01, 1'b0, c + 1);
      expect_ev(1, 2'b10, 1'b0, c + 2);
      expect_ev(2, 2'b00, 1'b0, c + 4);
      cmd0 = 2'b10;
      req  = 2'b01;
      wait_gnt(1);
      req = 2'b00;
      wait_done(1);
      chkv("s1_model", {6'd0, model}, 8'd2);

      // from mode 3, cmd 00 targets mode 2; pointer now favours 1
      sync();
      set_model(2'd3);
      c = cyc;
      expect_ev(0, 2'b10, 1'b0, c + 1);
      expect_ev(1, 2'b00, 1'b1, c + 2);
      expect_ev(2, 2'b00, 1'b0, c + 4);
      cmd1 = 2'b00;
      req  = 2'b10;
      wait_gnt(2);
      req = 2'b00;
      wait_done(2);
      chkv("s3_model", {6'd0, model}, 8'd2);

      // both requesting after reset: 01, 10, 01
      sync();
      rst = 1'b1;
      sync();
      sync();
      rst = 1'b0;
      sync();
      c = cyc;
      expect_ev(0, 2'b01, 1'b0, c + 1);
      expect_ev(1, 2'b01, 1'b0, c + 2);
      expect_ev(2, 2'b00, 1'b0, c + 4);
      expect_ev(0, 2'b10, 1'b0, c + 6);
      expect_ev(1, 2'b11, 1'b1, c + 7);
      expect_ev(2, 2'b00, 1'b0, c + 9);
      expect_ev(0, 2'b01, 1'b0, c + 11);
      expect_ev(1, 2'b01, 1'b0, c + 12);
      expect_ev(2, 2'b00, 1'b0, c + 14);
      cmd0 = 2'b01;
      cmd1 = 2'b11;
      req  = 2'b11;
      wait_gnt(5);
      req = 2'b00;
      wait_done(5);

      // stuck model: timeout after 8 wait cycles
      sync();
      follow = 1'b0;
      set_model(2'd1);
      c = cyc;
      expect_ev(0, 2'b10, 1'b0, c + 1);
      expect_ev(1, 2'b10, 1'b1, c + 2);
      expect_ev(2, 2'b01, 1'b0, c + 11);
      cmd1 = 2'b10;
      req  = 2'b10;
      wait_gnt(6);
      req = 2'b00;
      wait_done(6);
      sync();
      chkv("timeout_idle_busy", {7'd0, busy}, 8'd0);

      // request raised during wait is held off until after done
      c = cyc;
      expect_ev(0, 2'b01, 1'b0, c + 1);
      expect_ev(1, 2'b10, 1'b0, c + 2);
      expect_ev(2, 2'b01, 1'b0, c + 11);
      expect_ev(0, 2'b10, 1'b0, c + 13);
      expect_ev(1, 2'b01, 1'b1, c + 14);
      expect_ev(2, 2'b00, 1'b0, c + 16);
      cmd0 = 2'b10;
      req  = 2'b01;
      wait_gnt(7);
      req = 2'b00;
      while (cyc < c + 5) sync();
      chkv("late_req_busy", {7'd0, busy}, 8'd1);
      cmd1 = 2'b01;
      req  = 2'b10;
      wait_gnt(8);
      req = 2'b00;
      wait_done(8);

      // reset during wait abandons the transaction
      sync();
      c = cyc;
      expect_ev(0, 2'b01, 1'b0, c + 1);
      expect_ev(1, 2'b10, 1'b0, c + 2);
      cmd0 = 2'b10;
      req  = 2'b01;
      wait_gnt(9);
      req = 2'b00;
      while (cyc < c + 5) sync();
      chkv("mid_busy", {7'd0, busy}, 8'd1);
      #1;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      sync();
      sync();
      rst = 1'b0;
      sync();
      follow = 1'b1;
      c = cyc;
      expect_ev(0, 2'b01, 1'b0, c + 1);
      expect_ev(1, 2'b01, 1'b0, c + 2);
      expect_ev(2, 2'b00, 1'b0, c + 4);
      cmd0 = 2'b01;
      cmd1 = 2'b00;
      req  = 2'b11;
      wait_gnt(10);
      req = 2'b00;
      wait_done(9);

      repeat (4) sync();
      chkv("queue_drained", 8'(q.size()), 8'd0);
      chkv("done_count", 8'(n_done), 8'd9);

      $display("CHECKS %0d ERRORS %0d", chk, errs);
      $finish;
   end

endmodule
